// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: central arbiter for the serial master/slave bus.
// Grants one master at a time, fixed-priority or round-robin (chosen in IDLE),
// holds the grant while bus_util is high, and forces a release when the granted
// master never starts (accept watchdog) or never finishes (hold watchdog).
// Every grant ends with a one-cycle no-grant turnaround (RELEASE).
//
// Ports:
//   clk          bus clock, rising edge
//   rstn         asynchronous active-low reset
//   rr_mode      1 = round-robin, 0 = fixed priority (index 0 highest)
//   m_reqs       level request per master
//   bus_util     wired-OR bus-utilising line
//   slaves       per-slave busy (outstanding split transaction)
//   m_grants     one-hot grant (registered)
//   state        FSM state: IDLE=0, GRANT=1, BUSY=2, RELEASE=3
//   mid_current  index of the current / last granted master
//   timeout      one-cycle pulse on any watchdog expiry
module bus_arbiter_rr #(
   parameter int unsigned N_MASTERS  = 12,
   parameter int unsigned N_SLAVES   = 6,
   parameter int unsigned ACCEPT_LEN = 4,
   parameter int unsigned HOLD_LEN   = 10
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 rr_mode,
   input  logic [N_MASTERS-1:0] m_reqs,
   input  logic                 bus_util,
   input  logic [N_SLAVES-1:0]  slaves,
   output logic [N_MASTERS-1:0] m_grants,
   output logic [3:0]           state,
   output logic [3:0]           mid_current,
   output logic                 timeout
);

   localparam int unsigned IDX_W = 4;
   localparam int unsigned ACC_W = $clog2(ACCEPT_LEN + 1);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_GRANT   = 4'd1,
      S_BUSY    = 4'd2,
      S_RELEASE = 4'd3
   } state_t;

   state_t               state_q, state_d;
   logic [N_MASTERS-1:0] grants_d;
   logic [IDX_W-1:0]     mid_d;
   logic                 timeout_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d, ptr_wrap;
   logic [ACC_W-1:0]     acc_q, acc_d, acc_inc;
   logic [HOLD_LEN-1:0]  hold_q, hold_d, hold_inc;
   logic [IDX_W-1:0]     scan_start, winner;
   logic                 found;
   int unsigned          scan_idx;
   logic                 bus_idle, owner_req;

   assign state     = state_q;
   assign bus_idle  = ~bus_util & ~(|slaves);
   assign owner_req = |(m_reqs & (N_MASTERS'(1) << mid_current));
   assign acc_inc   = acc_q + ACC_W'(1);
   assign hold_inc  = hold_q + HOLD_LEN'(1);
   assign ptr_wrap  = (mid_current == IDX_W'(N_MASTERS - 1)) ? '0 : mid_current + IDX_W'(1);

   // Winner: first requester scanning upward from the start index, wrapping.
   // Fixed priority is the same scan started at 0.
   always_comb begin
      scan_start = rr_mode ? ptr_q : '0;
      winner     = '0;
      found      = 1'b0;
      scan_idx   = 0;
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
         scan_idx = 32'(scan_start) + i;
         if (scan_idx >= N_MASTERS) scan_idx = scan_idx - N_MASTERS;
         if (!found && |(m_reqs & (N_MASTERS'(1) << scan_idx))) begin
            found  = 1'b1;
            winner = IDX_W'(scan_idx);
         end
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      grants_d  = m_grants;
      mid_d     = mid_current;
      timeout_d = 1'b0;
      ptr_d     = ptr_q;
      acc_d     = acc_q;
      hold_d    = hold_q;
      case (state_q)
         S_IDLE: begin
            grants_d = '0;
            if (bus_idle && (|m_reqs)) begin
               state_d  = S_GRANT;
               grants_d = N_MASTERS'(1) << winner;
               mid_d    = winner;
               acc_d    = '0;
            end
         end
         S_GRANT: begin
            acc_d = acc_inc;
            if (bus_util) begin
               // Bus use takes precedence over a same-cycle withdrawal.
               state_d = S_BUSY;
               acc_d   = '0;
               hold_d  = '0;
            end else if (!owner_req) begin
               state_d  = S_RELEASE;
               grants_d = '0;
            end else if (acc_inc == ACC_W'(ACCEPT_LEN)) begin
               state_d   = S_RELEASE;
               grants_d  = '0;
               timeout_d = 1'b1;
            end
         end
         S_BUSY: begin
            hold_d = hold_inc;
            if (!bus_util) begin
               state_d  = S_RELEASE;
               grants_d = '0;
            end else if (&hold_inc) begin
               // Forced release even though the master still drives bus_util.
               state_d   = S_RELEASE;
               grants_d  = '0;
               timeout_d = 1'b1;
            end
         end
         S_RELEASE: begin
            grants_d = '0;
            ptr_d    = ptr_wrap;
            state_d  = S_IDLE;
         end
         default: begin
            state_d  = S_IDLE;
            grants_d = '0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         m_grants    <= '0;
         mid_current <= '0;
         timeout     <= 1'b0;
         ptr_q       <= '0;
         acc_q       <= '0;
         hold_q      <= '0;
      end else begin
         state_q     <= state_d;
         m_grants    <= grants_d;
         mid_current <= mid_d;
         timeout     <= timeout_d;
         ptr_q       <= ptr_d;
         acc_q       <= acc_d;
         hold_q      <= hold_d;
      end
   end

endmodule
